// File: rtl/out_arbiter_pkg.sv
// rtl/out_arbiter_pkg.sv - shared state type and helpers for the output arbiter
package out_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   function automatic int idx_width(input int n_srcs);
      return (n_srcs <= 1) ? 1 : $clog2(n_srcs);
   endfunction

   // Ones above the index field, source index below; the caller truncates to its word width.
   function automatic logic [63:0] hdr_word(input int idx_w, input logic [31:0] idx);
      return (~64'd0 << idx_w) | {32'd0, idx};
   endfunction

endpackage

// File: rtl/out_arbiter_if.sv
// rtl/out_arbiter_if.sv - writer-side and ft2232-side handshake bundle for out_arbiter
interface out_arbiter_if #(
   parameter int N_SRCS = 4,
   parameter int DATA_W = 8
);
   logic [N_SRCS*DATA_W-1:0] src_data_i;
   logic [N_SRCS-1:0]        src_req_i;
   logic [N_SRCS-1:0]        src_ack_o;
   logic [N_SRCS-1:0]        grant_o;
   logic [DATA_W-1:0]        out_o;
   logic                     out_req_o;
   logic                     out_ack_i;

   modport master (
      input  src_data_i, src_req_i, out_ack_i,
      output src_ack_o, grant_o, out_o, out_req_o
   );

   modport slave (
      output src_data_i, src_req_i, out_ack_i,
      input  src_ack_o, grant_o, out_o, out_req_o
   );
endinterface

// File: rtl/out_arbiter_rr_pick.sv
// rtl/out_arbiter_rr_pick.sv - cyclic priority picker: first requester at or after ptr
module out_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      logic          found;
      logic [IW-1:0] k;
      found = 1'b0;
      idx   = '0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         k = IW'((int'(ptr) + i) % N);
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
   end

   assign any = |req;
endmodule

// File: rtl/out_arbiter.sv
// rtl/out_arbiter.sv - round-robin merge of N_SRCS byte writers onto the ft2232 output port
// OUT_ARBITER_TAG_EN: prefix every burst with a {ones, source index} header word.
module out_arbiter
   import out_arbiter_pkg::*;
#(
   parameter int N_SRCS    = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input logic            clk_i,
   input logic            reset_ni,
   out_arbiter_if.master  bus
);
   localparam int IDX_W = idx_width(N_SRCS);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRCS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  cur_q, cur_d, rr_q, rr_d, pick_idx, nxt_idx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] out_q, load_word;
   logic [N_SRCS-1:0] ack;
   logic              out_req_q, load, load_ok, pick_any;

   out_arbiter_rr_pick #(.N(N_SRCS), .IW(IDX_W)) u_pick (
      .req (bus.src_req_i),
      .ptr (rr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign load_ok = !out_req_q || bus.out_ack_i;
   assign nxt_idx = (cur_q == LAST_IDX) ? '0 : cur_q + IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      load_word = '0;
      ack       = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               cur_d = pick_idx;
               cnt_d = '0;
`ifdef OUT_ARBITER_TAG_EN
               state_d = ST_HDR;
`else
               state_d = ST_DATA;
`endif
            end
         end
`ifdef OUT_ARBITER_TAG_EN
         ST_HDR: begin
            if (load_ok) begin
               load      = 1'b1;
               load_word = DATA_W'(hdr_word(IDX_W, 32'(cur_q)));
               state_d   = ST_DATA;
            end
         end
`endif
         ST_DATA: begin
            // A writer dropping its request gives up the rest of its burst.
            if (!bus.src_req_i[cur_q]) begin
               state_d = ST_IDLE;
               rr_d    = nxt_idx;
            end else if (load_ok) begin
               load      = 1'b1;
               load_word = bus.src_data_i[int'(cur_q)*DATA_W +: DATA_W];
               ack       = reset_ni ? (N_SRCS'(1) << cur_q) : '0;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  rr_d    = nxt_idx;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         rr_q      <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         out_req_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         if (load) begin
            out_q     <= load_word;
            out_req_q <= 1'b1;
         end else if (bus.out_ack_i) begin
            out_req_q <= 1'b0;
         end
      end
   end

   assign bus.src_ack_o = ack;
   assign bus.grant_o   = (state_q != ST_IDLE) ? (N_SRCS'(1) << cur_q) : '0;
   assign bus.out_o     = out_q;
   assign bus.out_req_o = out_req_q;
endmodule

// File: tb/tb_out_arbiter.sv
// tb/tb_out_arbiter.sv - directed bench with a round-robin stream model for out_arbiter
module tb_out_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 16;
`ifdef OUT_ARBITER_TAG_EN
   localparam int HW = 1;
`else
   localparam int HW = 0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   out_arbiter_if #(.N_SRCS(N), .DATA_W(DW)) bus ();

   out_arbiter #(.N_SRCS(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk_i    (clk),
      .reset_ni (rstn),
      .bus      (bus.master)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] wq [N][$];
   logic [DW-1:0] exp_q[$];
   int m_ptr = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int ack_cnt [N] = '{default: 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // Expected stream: visit writers cyclically from the pointer, each taking up to MB queued words.
   function automatic void model_plan();
      int  pos [N];
      int  k, left, n;
      bit  found;
      for (int s = 0; s < N; s++) pos[s] = 0;
      k = 0;
      while (1) begin
         found = 0;
         for (int i = 0; i < N && !found; i++) begin
            k = (m_ptr + i) % N;
            if (pos[k] < wq[k].size()) found = 1;
         end
         if (!found) break;
         if (HW != 0) exp_q.push_back(8'hFC | 8'(k));
         left = wq[k].size() - pos[k];
         n = (left < MB) ? left : MB;
         for (int j = 0; j < n; j++) exp_q.push_back(wq[k][pos[k] + j]);
         pos[k] += n;
         m_ptr = (k + 1) % N;
      end
   endfunction

   function automatic bit all_empty();
      bit e;
      e = 1;
      for (int k = 0; k < N; k++) if (wq[k].size() != 0) e = 0;
      return e;
   endfunction

   task automatic push_words(input int src, input logic [DW-1:0] base, input int cnt);
      for (int i = 0; i < cnt; i++) wq[src].push_back(base + DW'(i));
   endtask

   task automatic wait_drain(input string name, input int budget);
      int t;
      bit done;
      t = 0;
      done = 0;
      while (!done && t < budget) begin
         @(negedge clk);
         t++;
         done = (exp_q.size() == 0) && (bus.grant_o == '0) && !bus.out_req_o && all_empty();
      end
      check(name, 32'(done), 32'd1);
   endtask

   // Writers: sole driver of src_req_i/src_data_i; pop on each observed ack.
   initial begin
      logic [N-1:0]    a;
      logic [N*DW-1:0] d;
      logic [N-1:0]    r;
      bus.src_req_i  = '0;
      bus.src_data_i = '0;
      forever begin
         @(negedge clk);
         a = bus.src_ack_o;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (a[k] && wq[k].size() > 0) begin
               void'(wq[k].pop_front());
               ack_cnt[k]++;
            end
         end
         d = '0;
         r = '0;
         for (int k = 0; k < N; k++) begin
            if (wq[k].size() > 0) begin
               r[k] = 1'b1;
               d[k*DW +: DW] = wq[k][0];
            end
         end
         bus.src_req_i  = r;
         bus.src_data_i = d;
      end
   end

   // Per-cycle compare against the model stream and handshake rules.
   initial begin
      bit            prev_hold;
      logic [DW-1:0] prev_out;
      prev_hold = 0;
      prev_out  = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_hold = 0;
         end else begin
            check("ack_onehot", 32'($countones(bus.src_ack_o) <= 1), 32'd1);
            check("ack_in_grant", 32'(bus.src_ack_o & ~bus.grant_o), 32'd0);
            check("ack_needs_req", 32'(bus.src_ack_o & ~bus.src_req_i), 32'd0);
            check("grant_onehot0", 32'($countones(bus.grant_o) <= 1), 32'd1);
            if (bus.out_req_o && !bus.out_ack_i) check("stall_no_ack", 32'(bus.src_ack_o), 32'd0);
            if (prev_hold) begin
               check("hold_req", 32'(bus.out_req_o), 32'd1);
               check("hold_data", 32'(bus.out_o), 32'(prev_out));
            end
            if (bus.out_req_o && bus.out_ack_i) begin
               if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
               else check("stream_word", 32'(bus.out_o), 32'(exp_q.pop_front()));
            end
            prev_hold = bus.out_req_o && !bus.out_ack_i;
            prev_out  = bus.out_o;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            a_base;
      logic [DW-1:0] frozen;
      int            t;
      bit            seen;
      bus.out_ack_i = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_req", 32'(bus.out_req_o), 32'd0);
      check("rst_out_o", 32'(bus.out_o), 32'd0);
      check("rst_grant", 32'(bus.grant_o), 32'd0);
      check("rst_ack", 32'(bus.src_ack_o), 32'd0);
      @(posedge clk); #2 rstn = 1'b1;

      // single writer, three words, latency
      @(posedge clk); #2;
      a_base = ack_cnt[0];
      wq[0].push_back(8'hA1); wq[0].push_back(8'hA2); wq[0].push_back(8'hA3);
      model_plan();
      check("t1_model_len", 32'(exp_q.size()), 32'(3 + HW));
      check("t1_model_first", 32'(exp_q[0]), 32'(HW != 0 ? 8'hFC : 8'hA1));
      @(negedge clk);
      @(negedge clk);
      check("t1_idle_grant", 32'(bus.grant_o), 32'd0);
      check("t1_idle_req", 32'(bus.out_req_o), 32'd0);
      @(negedge clk);
      check("t1_grant", 32'(bus.grant_o), 32'b0001);
      check("t1_req_low", 32'(bus.out_req_o), 32'd0);
      check("t1_first_ack", 32'(bus.src_ack_o), 32'(HW != 0 ? 4'b0000 : 4'b0001));
      @(negedge clk);
      check("t1_req_high", 32'(bus.out_req_o), 32'd1);
      check("t1_first_out", 32'(bus.out_o), 32'(HW != 0 ? 8'hFC : 8'hA1));
      wait_drain("t1_drain", 100);
      check("t1_ack_count", 32'(ack_cnt[0] - a_base), 32'd3);

      // downstream stall mid-burst
      @(posedge clk); #2;
      push_words(0, 8'h30, 20);
      model_plan();
      repeat (6) @(posedge clk);
      #2 bus.out_ack_i = 1'b0;
      @(negedge clk);
      frozen = bus.out_o;
      check("t3_stall_req", 32'(bus.out_req_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("t3_stall_noack", 32'(bus.src_ack_o), 32'd0);
         check("t3_stall_out", 32'(bus.out_o), 32'(frozen));
      end
      @(posedge clk); #2 bus.out_ack_i = 1'b1;
      wait_drain("t3_drain", 200);

      // early drop by source 1 hands the port to source 3
      @(posedge clk); #2;
      a_base = ack_cnt[1];
      push_words(1, 8'h41, 2);
      push_words(3, 8'hC0, 5);
      model_plan();
      check("t4_model_len", 32'(exp_q.size()), 32'(7 + 2*HW));
      check("t4_model_src1", 32'(exp_q[HW]), 32'h41);
      check("t4_model_src3", 32'(exp_q[2 + 2*HW]), 32'hC0);
      t = 0;
      seen = 0;
      while (!seen && t < 50) begin
         @(negedge clk);
         t++;
         seen = (bus.grant_o == 4'b1000);
      end
      check("t4_grant_moves", 32'(seen), 32'd1);
      wait_drain("t4_drain", 100);
      check("t4_ack_count", 32'(ack_cnt[1] - a_base), 32'd2);

      // two long writers share the port in MAX_BURST slices
      @(posedge clk); #2;
      push_words(0, 8'h00, 40);
      push_words(2, 8'h80, 40);
      model_plan();
      check("t2_model_len", 32'(exp_q.size()), 32'(80 + 6*HW));
      check("t2_model_b0", 32'(exp_q[HW]), 32'h00);
      check("t2_model_b1", 32'(exp_q[16 + 2*HW]), 32'h80);
      check("t2_model_b2", 32'(exp_q[32 + 3*HW]), 32'h10);
      check("t2_model_b4", 32'(exp_q[64 + 5*HW]), 32'h20);
      check("t2_model_b5", 32'(exp_q[72 + 6*HW]), 32'hA0);
      wait_drain("t2_drain", 400);

      // header words (raw stream when tagging is off)
      @(posedge clk); #2;
      wq[3].push_back(8'h55);
      wq[1].push_back(8'h11);
      model_plan();
      check("t5_model_w0", 32'(exp_q[0]), 32'(HW != 0 ? 8'hFF : 8'h55));
      check("t5_model_w1", 32'(exp_q[HW]), 32'h55);
      check("t5_model_w2", 32'(exp_q[1 + HW]), 32'(HW != 0 ? 8'hFD : 8'h11));
      check("t5_model_w3", 32'(exp_q[1 + 2*HW]), 32'h11);
      wait_drain("t5_drain", 100);

      // reset in the middle of a burst
      @(posedge clk); #2;
      push_words(2, 8'h80, 20);
      model_plan();
      repeat (6) @(posedge clk);
      #2;
      check("t6_busy", 32'(bus.out_req_o), 32'd1);
      rstn = 1'b0;
      for (int k = 0; k < N; k++) wq[k].delete();
      exp_q.delete();
      m_ptr = 0;
      @(posedge clk); #2 rstn = 1'b1;
      @(negedge clk);
      check("t6_req_cleared", 32'(bus.out_req_o), 32'd0);
      check("t6_grant_cleared", 32'(bus.grant_o), 32'd0);
      @(posedge clk); #2;
      push_words(1, 8'h61, 3);
      push_words(3, 8'hE1, 3);
      model_plan();
      check("t6_model_first", 32'(exp_q[HW]), 32'h61);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t6_ptr_reset_grant", 32'(bus.grant_o), 32'b0010);
      wait_drain("t6_drain", 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
